alu6_sequencer: RTL and testbench

//  Control sequencer sitting directly upstream of the 6-bit ALU datapath.
//  - Accepts an operation request over a start/busy/done handshake.
//  - Drives the datapath strobes: load/hold/shift, operand mux select,

---
 rtl/alu6_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu6_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu6_sequencer.sv
// Control sequencer for the 6-bit ALU datapath: start/busy/done handshake, datapath strobes,
// programmable accumulate loop and result capture. Optional abort input: ALU6_SEQ_ABORT_EN.
module alu6_sequencer #(
    parameter int unsigned W       = 6,
    parameter int unsigned COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [COUNT_W-1:0] count,
    input  logic [W-1:0]       alu_r1,
    input  logic               alu_q,
`ifdef ALU6_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic               load,
    output logic               hold,
    output logic               shift,
    output logic [1:0]         opt,
    output logic               opt2,
    output logic [1:0]         c,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [W-1:0]       result,
    output logic               carry
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DBL = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_ADC = 3'b100;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t               state, state_nxt;
    logic [2:0]           op_q, op_nxt;
    logic [COUNT_W-1:0]   cnt, cnt_nxt;
    logic                 load_nxt, hold_nxt, shift_nxt, opt2_nxt;
    logic                 busy_nxt, done_nxt, err_nxt;
    logic [1:0]           opt_nxt, c_nxt;

    // Next state, then the outputs that belong to that next state so they can be registered.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        load_nxt  = 1'b0;
        hold_nxt  = 1'b1;
        shift_nxt = 1'b0;
        opt_nxt   = 2'b00;
        opt2_nxt  = 1'b0;
        c_nxt     = 2'b01;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt  = op;
                    cnt_nxt = (count == '0) ? COUNT_W'(1) : count;
                    if (op > OP_ADC) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: state_nxt = EXEC;
            EXEC: begin
                if (cnt == COUNT_W'(1)) state_nxt = DONE;
                else                    cnt_nxt   = cnt - COUNT_W'(1);
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

`ifdef ALU6_SEQ_ABORT_EN
        // Abort overrides any LOAD/EXEC transition, including the final iteration.
        if (abort && (state == LOAD || state == EXEC)) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
        end
`endif

        case (state_nxt)
            IDLE: busy_nxt = 1'b0;
            LOAD: begin
                load_nxt = 1'b1;
                hold_nxt = 1'b0;
                case (op_nxt)
                    OP_SUB: begin
                        c_nxt    = 2'b10;
                        opt2_nxt = 1'b1;
                    end
                    OP_ADC:  c_nxt = 2'b01;
                    default: c_nxt = 2'b00;
                endcase
            end
            EXEC: begin
                shift_nxt = 1'b1;
                hold_nxt  = 1'b0;
                case (op_nxt)
                    OP_SUB:  opt_nxt = 2'b01;
                    OP_DBL:  opt_nxt = 2'b10;
                    OP_DEC:  opt_nxt = 2'b11;
                    default: opt_nxt = 2'b00;
                endcase
                if (cnt_nxt == COUNT_W'(1)) begin
                    c_nxt = 2'b11;
                end else if (op_nxt == OP_SUB) begin
                    c_nxt    = 2'b10;
                    opt2_nxt = 1'b1;
                end else begin
                    c_nxt = 2'b00;
                end
            end
            DONE: done_nxt = 1'b1;
            default: busy_nxt = 1'b0;
        endcase
    end

    // State, latched request and registered outputs; result/carry written as the done cycle closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            cnt    <= '0;
            load   <= 1'b0;
            hold   <= 1'b1;
            shift  <= 1'b0;
            opt    <= 2'b00;
            opt2   <= 1'b0;
            c      <= 2'b01;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            cnt    <= cnt_nxt;
            load   <= load_nxt;
            hold   <= hold_nxt;
            shift  <= shift_nxt;
            opt    <= opt_nxt;
            opt2   <= opt2_nxt;
            c      <= c_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
            if (state == DONE && !err) begin
                result <= alu_r1;
                carry  <= alu_q;
            end
        end
    end

endmodule

// File: tb/tb_alu6_sequencer.sv
// Directed bench: alu6_sequencer driving a small 6-bit ALU datapath model.
module tb_alu6_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [3:0] count = 4'd1;
    logic [5:0] a_in = 6'd0;
    logic [5:0] b_in = 6'd0;
`ifdef ALU6_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       load, hold, shift, opt2, busy, done, err, carry;
    logic [1:0] opt, c;
    logic [5:0] result;

    logic [5:0] r1 = 6'd0;
    logic [5:0] r2 = 6'd0;
    logic       q = 1'b0;
    logic [5:0] x;
    logic [6:0] sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu6_sequencer #(.W(6), .COUNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .count(count),
        .alu_r1(r1), .alu_q(q),
`ifdef ALU6_SEQ_ABORT_EN
        .abort(abort),
`endif
        .load(load), .hold(hold), .shift(shift), .opt(opt), .opt2(opt2), .c(c),
        .busy(busy), .done(done), .err(err), .result(result), .carry(carry)
    );

    // Datapath: Q feeds the adder carry-in; the carry mux chooses Q's next value.
    always_comb begin
        case (opt)
            2'b00:   x = r2;
            2'b01:   x = ~r2;
            2'b10:   x = r1;
            default: x = 6'h3f;
        endcase
        sum = {1'b0, r1} + {1'b0, x} + {6'd0, q};
    end

    always @(posedge clk) begin
        case (c)
            2'b00:   q <= 1'b0;
            2'b01:   q <= q;
            2'b10:   q <= opt2;
            default: q <= sum[6];
        endcase
        if (load)       begin r1 <= a_in; r2 <= b_in; end
        else if (shift) r1 <= sum[5:0];
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request and run it to done; with inject, start stays high (with a different op) while busy.
    task automatic run_op(input logic [2:0] o, input logic [5:0] a, input logic [5:0] b,
                          input logic [3:0] n, input bit inject,
                          output int lat, output int loads, output int shifts, output int e);
        @(negedge clk);
        op = o; a_in = a; b_in = b; count = n; start = 1'b1;
        @(negedge clk);
        if (inject) op = 3'b001;
        else start = 1'b0;
        lat = 1; loads = 0; shifts = 0; e = 0;
        while (!done && lat < 40) begin
            if (load)  loads++;
            if (shift) shifts++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", lat, -1);
        e = int'(err);
        start = 1'b0;
        @(negedge clk);
    endtask

    int lat, ld, sh, e;

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_hold", hold, 1);
        check("rst_c", c, 1);
        check("rst_result", result, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op(3'b000, 6'd5, 6'd3, 4'd1, 0, lat, ld, sh, e);
        check("add_lat", lat, 3);
        check("add_loads", ld, 1);
        check("add_shifts", sh, 1);
        check("add_err", e, 0);
        check("add_result", result, 8);
        check("add_carry", carry, 0);
        check("add_idle_busy", busy, 0);

        run_op(3'b001, 6'd5, 6'd7, 4'd1, 0, lat, ld, sh, e);
        check("sub57_result", result, 62);
        check("sub57_carry", carry, 0);
        run_op(3'b001, 6'd7, 6'd5, 4'd1, 0, lat, ld, sh, e);
        check("sub75_result", result, 2);
        check("sub75_carry", carry, 1);

        run_op(3'b000, 6'd1, 6'd10, 4'd7, 0, lat, ld, sh, e);
        check("add7_lat", lat, 9);
        check("add7_shifts", sh, 7);
        check("add7_result", result, 7);
        check("add7_carry", carry, 1);

        run_op(3'b011, 6'd0, 6'd0, 4'd1, 0, lat, ld, sh, e);
        check("dec_result", result, 63);
        check("dec_carry", carry, 0);
        run_op(3'b010, 6'd40, 6'd0, 4'd1, 0, lat, ld, sh, e);
        check("dbl_result", result, 16);
        check("dbl_carry", carry, 1);
        run_op(3'b100, 6'd1, 6'd1, 4'd1, 0, lat, ld, sh, e);
        check("adc_result", result, 3);
        check("adc_carry", carry, 0);

        run_op(3'b000, 6'd5, 6'd3, 4'd0, 0, lat, ld, sh, e);
        check("cnt0_shifts", sh, 1);
        check("cnt0_result", result, 8);
        run_op(3'b000, 6'd0, 6'd1, 4'd15, 0, lat, ld, sh, e);
        check("cnt15_lat", lat, 17);
        check("cnt15_shifts", sh, 15);
        check("cnt15_result", result, 15);

        run_op(3'b111, 6'd9, 6'd9, 4'd3, 0, lat, ld, sh, e);
        check("ill_lat", lat, 1);
        check("ill_err", e, 1);
        check("ill_loads", ld, 0);
        check("ill_shifts", sh, 0);

        run_op(3'b000, 6'd2, 6'd3, 4'd2, 1, lat, ld, sh, e);
        check("busy_start_lat", lat, 4);
        check("busy_start_result", result, 8);
        check("busy_start_idle", busy, 0);
        @(negedge clk);
        check("busy_start_not_queued", busy, 0);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        op = 3'b000; a_in = 6'd1; b_in = 6'd1; count = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_shift", shift, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_shift", shift, 0);
        check("arst_busy", busy, 0);
        check("arst_hold", hold, 1);
        check("arst_c", c, 1);
        check("arst_result", result, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef ALU6_SEQ_ABORT_EN
        run_op(3'b000, 6'd5, 6'd3, 4'd1, 0, lat, ld, sh, e);
        check("pre_abort_result", result, 8);
        @(negedge clk);
        op = 3'b000; a_in = 6'd1; b_in = 6'd1; count = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_err", err, 1);
        @(negedge clk);
        check("abort_result", result, 8);
        check("abort_busy", busy, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_done", done, 0);
        check("abort_idle_busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
